// File: rtl/tlut_prod_gen.sv
// Temporal-LUT product generator: multiplies each row of a by its scalar b by accumulating a for b cycles.
// Build option TLUT_EARLY_TERM_EN ends the accumulation after max(b) cycles instead of the full 2^DATA_WIDTH-1.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high, prod holds last result
// RUN   | accumulating a into prod while cnt < b for each row
// DONE  | prod complete, out_valid high until out_ready
module tlut_prod_gen #(
    parameter int DIM_C      = 2,
    parameter int DIM_A      = 2,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DIM_C-1:0][DIM_A-1:0][DATA_WIDTH-1:0]   a_in,
    input  logic [DIM_C-1:0][DATA_WIDTH-1:0]              b_in,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    prod,
    output logic                                          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                    state, state_nxt;
    logic [DATA_WIDTH-1:0]                     cnt;
    logic [DIM_C-1:0][DIM_A-1:0][DATA_WIDTH-1:0] a_q;
    logic [DIM_C-1:0][DATA_WIDTH-1:0]          b_q;
    logic                                      accept;
    logic                                      run_last;
    logic                                      skip_run;

`ifdef TLUT_EARLY_TERM_EN
    logic [DATA_WIDTH-1:0] bmax_in, bmax_q;

    always_comb begin
        bmax_in = '0;
        for (int c = 0; c < DIM_C; c++) begin
            if (b_in[c] > bmax_in) bmax_in = b_in[c];
        end
    end

    assign run_last = (cnt == (bmax_q - DATA_WIDTH'(1)));
    assign skip_run = (bmax_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bmax_q <= '0;
        end else if (accept) begin
            bmax_q <= bmax_in;
        end
    end
`else
    // Last RUN edge sees cnt == 2^W-2, so RUN lasts 2^W-1 cycles and b = 2^W-1 adds every cycle.
    localparam logic [DATA_WIDTH-1:0] CNT_LAST = DATA_WIDTH'(2**DATA_WIDTH - 2);

    assign run_last = (cnt == CNT_LAST);
    assign skip_run = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = skip_run ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (run_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            prod <= '0;
        end else if (accept) begin
            a_q  <= a_in;
            b_q  <= b_in;
            cnt  <= '0;
            prod <= '0;
        end else if (state == RUN) begin
            for (int c = 0; c < DIM_C; c++) begin
                for (int j = 0; j < DIM_A; j++) begin
                    if (cnt < b_q[c]) begin
                        prod[c][j] <= prod[c][j] +
                                      {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a_q[c][j]};
                    end
                end
            end
            cnt <= cnt + DATA_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tlut_prod_gen.sv
// Scoreboard bench for tlut_prod_gen: expected products queued at accept, compared when out_valid appears.
module tb_tlut_prod_gen;

    localparam int DC = 2;
    localparam int DA = 2;
    localparam int DW = 4;
    localparam int AW = 16;

    typedef logic [DC-1:0][DA-1:0][DW-1:0] a_t;
    typedef logic [DC-1:0][DW-1:0]         b_t;
    typedef logic [DC-1:0][DA-1:0][AW-1:0] mat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    a_t   a_in = '0;
    b_t   b_in = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    mat_t prod;
    logic busy;

    int   total = 0;
    int   bad   = 0;
    mat_t sb[$];

    always #5 clk = ~clk;

    tlut_prod_gen #(
        .DIM_C(DC), .DIM_A(DA), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .busy(busy)
    );

    function automatic mat_t model(input a_t a, input b_t b);
        mat_t m;
        for (int c = 0; c < DC; c++)
            for (int j = 0; j < DA; j++)
                m[c][j] = AW'(a[c][j]) * AW'(b[c]);
        return m;
    endfunction

    function automatic int exp_lat(input b_t b);
`ifdef TLUT_EARLY_TERM_EN
        int mx = 0;
        for (int c = 0; c < DC; c++) if (int'(b[c]) > mx) mx = int'(b[c]);
        return mx;
`else
        return (2**DW) - 1;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input a_t a, input b_t b);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        step;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_n++;
            step;
            lat++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL wait_out: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic pop_check(input string name, output mat_t exp);
        total++;
        if (sb.size() == 0) begin
            bad++;
            exp = '0;
            $display("FAIL %s: scoreboard empty, prod=%h", name, prod);
        end else begin
            exp = sb.pop_front();
            if (prod !== exp) begin
                bad++;
                $display("FAIL %s: prod=%h required %h", name, prod, exp);
            end
        end
    endtask

    task automatic check_lat(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: latency=%0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        total++; if (prod !== '0)     begin bad++; $display("FAIL reset_prod: prod=%h required 0", prod); end
        total++; if (out_valid !== 0) begin bad++; $display("FAIL reset_out_valid: %0b required 0", out_valid); end
        total++; if (busy !== 0)      begin bad++; $display("FAIL reset_busy: %0b required 0", busy); end
        step;
        #2 rst = 1'b0;
        step;
        total++; if (in_ready !== 1)  begin bad++; $display("FAIL reset_in_ready: %0b required 1", in_ready); end
    endtask

    task automatic test_basic;
        a_t a = {4'd3, 4'd5, 4'd7, 4'd1};
        b_t b = {4'd2, 4'd4};
        mat_t req = {16'd6, 16'd10, 16'd28, 16'd4};
        mat_t exp;
        int lat, bn;
        out_ready = 1'b1;
        send(a, b);
        wait_out(lat, bn);
        check_lat("basic_latency", lat, exp_lat(b));
        pop_check("basic_prod", exp);
        total++; if (prod !== req) begin bad++; $display("FAIL basic_const: prod=%h required %h", prod, req); end
        step;
        total++; if (out_valid !== 0) begin bad++; $display("FAIL basic_one_cycle: out_valid=%0b required 0", out_valid); end
        total++; if (in_ready !== 1)  begin bad++; $display("FAIL basic_in_ready: %0b required 1", in_ready); end
        total++; if (prod !== req)    begin bad++; $display("FAIL basic_idle_hold: prod=%h required %h", prod, req); end
    endtask

    task automatic test_full;
        a_t a = '1;
        b_t b = '1;
        mat_t exp;
        int lat, bn;
        send(a, b);
        wait_out(lat, bn);
        check_lat("full_latency", lat, exp_lat(b));
        check_lat("full_busy_cycles", bn, 15);
        pop_check("full_prod", exp);
        total++; if (prod[1][0] !== 16'd225) begin bad++; $display("FAIL full_225: prod=%0d required 225", prod[1][0]); end
        step;
    endtask

    task automatic test_zero_row;
        a_t a = {4'd8, 4'd8, 4'd2, 4'd0};
        b_t b = {4'd0, 4'd9};
        mat_t req = {16'd0, 16'd0, 16'd18, 16'd0};
        mat_t exp;
        int lat, bn;
        send(a, b);
        wait_out(lat, bn);
        pop_check("zero_row_prod", exp);
        total++; if (prod !== req) begin bad++; $display("FAIL zero_row_const: prod=%h required %h", prod, req); end
        step;
    endtask

    task automatic test_backpressure;
        a_t a = {4'd9, 4'd4, 4'd6, 4'd11};
        b_t b = {4'd7, 4'd13};
        mat_t exp;
        int lat, bn;
        out_ready = 1'b0;
        send(a, b);
        wait_out(lat, bn);
        pop_check("bp_prod", exp);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a_in = a_t'($urandom);
            b_in = b_t'($urandom);
            step;
            total++; if (out_valid !== 1) begin bad++; $display("FAIL bp_out_valid[%0d]: %0b required 1", i, out_valid); end
            total++; if (in_ready !== 0)  begin bad++; $display("FAIL bp_in_ready[%0d]: %0b required 0", i, in_ready); end
            total++; if (prod !== exp)    begin bad++; $display("FAIL bp_prod_stable[%0d]: prod=%h required %h", i, prod, exp); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        total++; if (out_valid !== 0) begin bad++; $display("FAIL bp_release: out_valid=%0b required 0", out_valid); end
        total++; if (in_ready !== 1)  begin bad++; $display("FAIL bp_release_ready: %0b required 1", in_ready); end
        total++; if (prod !== exp)    begin bad++; $display("FAIL bp_after_release: prod=%h required %h", prod, exp); end
    endtask

    task automatic test_reset_mid_run;
        a_t a = {4'd5, 4'd5, 4'd5, 4'd5};
        b_t b = {4'd9, 4'd9};
        a_t a2 = {4'd12, 4'd1, 4'd0, 4'd14};
        b_t b2 = {4'd5, 4'd11};
        mat_t exp;
        int lat, bn;
        bit seen;
        send(a, b);
        for (int i = 0; i < 7; i++) step;
        #2 rst = 1'b1;
        #1;
        sb.delete();
        total++; if (prod !== '0)     begin bad++; $display("FAIL rst_run_prod: prod=%h required 0", prod); end
        total++; if (out_valid !== 0) begin bad++; $display("FAIL rst_run_out_valid: %0b required 0", out_valid); end
        total++; if (busy !== 0)      begin bad++; $display("FAIL rst_run_busy: %0b required 0", busy); end
        #2 rst = 1'b0;
        step;
        total++; if (in_ready !== 1)  begin bad++; $display("FAIL rst_run_in_ready: %0b required 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            step;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_run_no_pulse: out_valid seen=%0b required 0", seen); end
        send(a2, b2);
        wait_out(lat, bn);
        check_lat("rst_fresh_latency", lat, exp_lat(b2));
        pop_check("rst_fresh_prod", exp);
        step;
    endtask

    task automatic test_early_term;
        a_t a = {4'd2, 4'd3, 4'd4, 4'd5};
        b_t b = {4'd3, 4'd1};
        b_t bz = '0;
        mat_t exp;
        int lat, bn;
        send(a, b);
        wait_out(lat, bn);
        check_lat("early_latency", lat, exp_lat(b));
        pop_check("early_prod", exp);
        step;
        send(a, bz);
        wait_out(lat, bn);
        check_lat("early_zero_latency", lat, exp_lat(bz));
        pop_check("early_zero_prod", exp);
        total++; if (prod !== '0) begin bad++; $display("FAIL early_zero_const: prod=%h required 0", prod); end
        step;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_zero_row;
        test_backpressure;
        test_reset_mid_run;
        test_early_term;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
